alu_cmd_issuer: RTL and testbench
=================================

Name: alu_cmd_issuer

Overview:
- Sequential initiator for the 8-bit dataflow ALU: accepts operation commands on a valid/ready interface and drives the ALU operand and select lines.
- Registers the combinational ALU result one settle cycle later and returns it with flags on a second valid/ready interface.
- Sits between the control/test front end and the combinational ALU datapath. Supports an accumulate mode that chains results.

Parameters:
- WIDTH, 8, operand/result width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  issuer can accept a command.
- cmd_op  input  3  bit2: 0 = logic unit, 1 = arithmetic unit; bits1:0 = ALU select.
- cmd_a  input  WIDTH  operand A.
- cmd_b  input  WIDTH  operand B.
- cmd_use_acc  input  1  use last result as A instead of cmd_a.
- alu_a  output  WIDTH  ALU operand A.
- alu_b  output  WIDTH  ALU operand B.
- alu_s  output  2  ALU select; logic mapping is 00 AND, 01 OR, 10 XOR, 11 NOT A.
- alu_unit  output  1  0 = logic, 1 = arithmetic.
- alu_out  input  WIDTH  ALU result, combinational from alu_*.
- alu_cout  input  1  ALU carry out; meaningful only when alu_unit = 1.
- res_valid  output  1  result available.
- res_ready  input  1  consumer takes result.
- res_data  output  WIDTH  captured result.
- res_zero  output  1  res_data == 0.
- res_carry  output  1  captured carry; forced 0 for logic ops.

Behaviour:
- Reset: asynchronous, active-high.
  - All outputs and registers clear: alu_a/alu_b/alu_s/alu_unit = 0, res_valid = 0, res_data = 0, res_zero = 0, res_carry = 0, accumulator = 0, state = IDLE.
  - cmd_ready = 0 while rst is asserted.
  - Asserting rst mid-operation abandons the command with no result.
- FSM states: IDLE, ISSUE, CAPTURE, OUT.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready at a clock edge: latch operands into alu_a/alu_b, latch cmd_op into alu_s/alu_unit, and go to ISSUE.
  - alu_a = accumulator when cmd_use_acc = 1, else cmd_a.
- ISSUE: one settle cycle. ALU inputs are held stable; go to CAPTURE.
- CAPTURE: sample alu_out into res_data and into the accumulator.
  - Also sample res_carry = alu_unit & alu_cout, and res_zero = (alu_out == 0).
  - Set res_valid and go to OUT.
- OUT:
  - res_valid = 1; res_data and flags are held stable.
  - On res_ready = 1 at an edge: clear res_valid and go to IDLE.
- cmd_ready is 0 in ISSUE, CAPTURE and OUT.
- alu_* outputs hold their last values outside ISSUE/CAPTURE; they are not cleared.
- Latency: command accepted at edge N; res_valid = 1 after edge N+2. Minimum 4 cycles per command with res_ready tied high.
- Backpressure: res_ready low holds OUT indefinitely; no new command is accepted.
- res_ready asserted outside OUT is ignored.
- Accumulator:
  - Updates only in CAPTURE.
  - cmd_use_acc on the first command after reset uses 0.
- Arithmetic: result is truncated to WIDTH; carry is reported separately. No overflow flag.
- cmd_op values with bit2 = 1 pass bits1:0 through unchanged; their decode belongs to the arithmetic unit.

Optional Feature:
- Macro: ALU_CMD_PARITY_EN.
- When defined:
  - Adds output res_parity (1 bit) = XOR reduction of res_data.
  - res_parity is captured in CAPTURE and cleared by reset.
  - Adds input cmd_parity (1 bit).
  - A command whose cmd_parity does not equal XOR(cmd_a, cmd_b) is still executed, but res_parity is driven inverted in OUT as an error marker.
- When undefined: neither port exists; behaviour is otherwise identical.

Test Plan:
- Reset then single AND: cmd_op=000, a=0xF0, b=0x3C, res_ready=1 -> res_valid 2 edges after accept, res_data=0x30, res_zero=0, res_carry=0.
- XOR zero result: op=010, a=0x5A, b=0x5A -> res_data=0x00, res_zero=1. Then NOT: op=011, a=0x0F -> res_data=0xF0.
- Accumulate chain: OR a=0x01, b=0x02 -> 0x03. Next OR cmd_use_acc=1, cmd_a=0xFF, b=0x40 -> 0x43 (cmd_a ignored).
- Backpressure: hold res_ready=0 for 5 cycles -> res_valid and res_data stable, cmd_ready=0; cmd_valid pulses are ignored. Raise res_ready -> IDLE next edge, then cmd_ready=1.
- Arithmetic carry: op=1xx, model ALU returns alu_out=0x04, alu_cout=1 -> res_carry=1. Same values on a logic op -> res_carry=0.
- Reset mid-operation: assert rst in ISSUE -> res_valid never asserts, outputs = 0, accumulator = 0. After release, cmd_ready=1 the next cycle.

Source files
------------

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: sequential initiator for the 8-bit dataflow ALU.
// It accepts commands on a valid/ready port and drives the ALU operand and select lines.
// It captures the combinational ALU result one settle cycle later.
// It returns the result and flags on a second valid/ready port.
// Ports:
//   clk, rst (async active-high)
//   cmd_valid/cmd_ready, cmd_op, cmd_a, cmd_b, cmd_use_acc  : command in
//   alu_a, alu_b, alu_s, alu_unit, alu_out, alu_cout        : ALU side
//   res_valid/res_ready, res_data, res_zero, res_carry      : result out
// Optional feature macro: ALU_CMD_PARITY_EN.
//   When it is defined, the module adds cmd_parity (in) and res_parity (out).
//   res_parity is inverted when a command's parity is wrong.
module alu_cmd_issuer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_use_acc,
`ifdef ALU_CMD_PARITY_EN
    input  logic             cmd_parity,
    output logic             res_parity,
`endif
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_s,
    output logic             alu_unit,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_cout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zero,
    output logic             res_carry
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_OUT
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [1:0]       r_alu_s;
    logic             r_alu_unit;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_res_data;
    logic             r_res_zero;
    logic             r_res_carry;
    logic             w_accept;
    logic             w_capture;

    assign w_accept  = cmd_valid & cmd_ready;
    assign w_capture = (r_state == S_CAPTURE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_next = S_ISSUE;
            S_ISSUE:   w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_OUT;
            S_OUT:     if (res_ready) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Handshake outputs; cmd_ready is also held low while in reset
    always_comb begin
        cmd_ready = 1'b0;
        res_valid = 1'b0;
        case (r_state)
            S_IDLE:  cmd_ready = ~rst;
            S_OUT:   res_valid = 1'b1;
            default: ;
        endcase
    end

    // ALU drive registers: loaded on accept, otherwise held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_s    <= '0;
            r_alu_unit <= 1'b0;
        end else if (w_accept) begin
            r_alu_a    <= cmd_use_acc ? r_acc : cmd_a;
            r_alu_b    <= cmd_b;
            r_alu_s    <= cmd_op[1:0];
            r_alu_unit <= cmd_op[2];
        end
    end

    // Result capture; carry from the logic unit is meaningless, so mask it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_data  <= '0;
            r_res_zero  <= 1'b0;
            r_res_carry <= 1'b0;
            r_acc       <= '0;
        end else if (w_capture) begin
            r_res_data  <= alu_out;
            r_res_zero  <= (alu_out == '0);
            r_res_carry <= r_alu_unit & alu_cout;
            r_acc       <= alu_out;
        end
    end

`ifdef ALU_CMD_PARITY_EN
    logic r_perr;
    logic r_res_parity;

    // The parity error is latched at accept and folded into the captured parity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perr       <= 1'b0;
            r_res_parity <= 1'b0;
        end else begin
            if (w_accept) begin
                r_perr <= cmd_parity ^ (^(cmd_a ^ cmd_b));
            end
            if (w_capture) begin
                r_res_parity <= (^alu_out) ^ r_perr;
            end
        end
    end

    assign res_parity = r_res_parity;
`endif

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_s     = r_alu_s;
    assign alu_unit  = r_alu_unit;
    assign res_data  = r_res_data;
    assign res_zero  = r_res_zero;
    assign res_carry = r_res_carry;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: self-checking bench for alu_cmd_issuer.
// A behavioural ALU model closes the loop; a transaction-level reference predicts results.
module tb_alu_cmd_issuer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       cmd_use_acc;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [1:0] alu_s;
    logic       alu_unit;
    logic [7:0] alu_out;
    logic       alu_cout;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_zero;
    logic       res_carry;
`ifdef ALU_CMD_PARITY_EN
    logic       cmd_parity;
    logic       res_parity;
`endif

    int errors = 0;
    int checks = 0;
    logic [7:0] ref_acc;

    always #5 clk = ~clk;

    alu_cmd_issuer #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .cmd_use_acc(cmd_use_acc),
`ifdef ALU_CMD_PARITY_EN
        .cmd_parity(cmd_parity), .res_parity(res_parity),
`endif
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
        .alu_unit(alu_unit), .alu_out(alu_out), .alu_cout(alu_cout),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_zero(res_zero), .res_carry(res_carry)
    );

    // Environment ALU: {raw carry, result}. In logic ops, the raw carry is the
    // carry of a+b. It is deliberately noisy so that the issuer must mask it.
    function automatic logic [8:0] env_alu(input logic [2:0] op,
                                           input logic [7:0] a,
                                           input logic [7:0] b);
        int s;
        s = int'(a) + int'(b);
        case (op)
            3'b000:  env_alu = {s > 255, a & b};
            3'b001:  env_alu = {s > 255, a | b};
            3'b010:  env_alu = {s > 255, a ^ b};
            3'b011:  env_alu = {s > 255, ~a};
            3'b100:  env_alu = {s > 255, 8'(s)};
            3'b101:  env_alu = {a >= b, 8'(int'(a) - int'(b))};
            3'b110:  env_alu = {a == 8'hFF, 8'(int'(a) + 1)};
            default: env_alu = {1'b0, b};
        endcase
    endfunction

    always_comb {alu_cout, alu_out} = env_alu({alu_unit, alu_s}, alu_a, alu_b);

    // Issue one command and collect the result.
    // hold = number of cycles that res_ready is held low in OUT.
    task automatic run_cmd(input logic [2:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic ua,
                           input int hold,
                           output logic [7:0] d, output logic z,
                           output logic c, output int lat,
                           output logic to);
        int n;
        @(negedge clk);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua;
`ifdef ALU_CMD_PARITY_EN
        cmd_parity = ^(a ^ b);
`endif
        cmd_valid = 1'b1;
        res_ready = (hold == 0);
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        to = !cmd_ready;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!res_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        to = to | !res_valid;
        d = res_data; z = res_zero; c = res_carry;
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            res_ready = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
        cmd_use_acc = 1'b0; res_ready = 1'b1; ref_acc = '0;
`ifdef ALU_CMD_PARITY_EN
        cmd_parity = 1'b0;
`endif
        repeat (2) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: ready=%b valid=%b, need 0 0", cmd_ready, res_valid);
        end
        checks++;
        if ({res_data, res_zero, res_carry} !== 10'd0) begin
            errors++;
            $display("FAIL reset_res: got %h/%b/%b, need 0", res_data, res_zero, res_carry);
        end
        checks++;
        if ({alu_a, alu_b, alu_s, alu_unit} !== 19'd0) begin
            errors++;
            $display("FAIL reset_alu: got a=%h b=%h s=%b u=%b, need 0", alu_a, alu_b, alu_s, alu_unit);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: cmd_ready=%b, need 1", cmd_ready);
        end
    endtask

    task automatic test_and();
        logic [7:0] d; logic z, c, to; int lat;
        run_cmd(3'b000, 8'hF0, 8'h3C, 1'b0, 0, d, z, c, lat, to);
        ref_acc = 8'h30;
        checks++;
        if (to || lat != 2) begin
            errors++;
            $display("FAIL and_latency: got %0d (timeout=%b), need 2", lat, to);
        end
        checks++;
        if ({d, z, c} !== {8'h30, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL and_result: got %h/%b/%b, need 30/0/0", d, z, c);
        end
    endtask

    task automatic test_xor_not();
        logic [7:0] d; logic z, c, to; int lat;
        run_cmd(3'b010, 8'h5A, 8'h5A, 1'b0, 0, d, z, c, lat, to);
        checks++;
        if (to || d !== 8'h00 || z !== 1'b1) begin
            errors++;
            $display("FAIL xor_zero: got %h z=%b, need 00 z=1", d, z);
        end
        run_cmd(3'b011, 8'h0F, 8'h77, 1'b0, 0, d, z, c, lat, to);
        ref_acc = 8'hF0;
        checks++;
        if (to || d !== 8'hF0 || z !== 1'b0 || c !== 1'b0) begin
            errors++;
            $display("FAIL not_a: got %h z=%b c=%b, need F0 0 0", d, z, c);
        end
    endtask

    task automatic test_accumulate();
        logic [7:0] d; logic z, c, to; int lat;
        run_cmd(3'b001, 8'h01, 8'h02, 1'b0, 0, d, z, c, lat, to);
        checks++;
        if (to || d !== 8'h03) begin
            errors++;
            $display("FAIL acc_first: got %h, need 03", d);
        end
        run_cmd(3'b001, 8'hFF, 8'h40, 1'b1, 0, d, z, c, lat, to);
        ref_acc = 8'h43;
        checks++;
        if (to || d !== 8'h43) begin
            errors++;
            $display("FAIL acc_chain: got %h, need 43", d);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] d0;
        int n;
        @(negedge clk);
        cmd_op = 3'b010; cmd_a = 8'hA5; cmd_b = 8'h0F; cmd_use_acc = 1'b0;
`ifdef ALU_CMD_PARITY_EN
        cmd_parity = ^(cmd_a ^ cmd_b);
`endif
        cmd_valid = 1'b1; res_ready = 1'b0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!res_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        ref_acc = 8'hAA;
        d0 = res_data;
        checks++;
        if (!res_valid || d0 !== 8'hAA) begin
            errors++;
            $display("FAIL bp_first: valid=%b data=%h, need 1 AA", res_valid, d0);
        end
        for (int i = 0; i < 5; i++) begin
            cmd_valid = i[0]; cmd_a = 8'(i * 17); cmd_use_acc = 1'b0;
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || res_data !== 8'hAA || cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b data=%h ready=%b, need 1 AA 0", i, res_valid, res_data, cmd_ready);
            end
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: valid=%b ready=%b, need 0 1", res_valid, cmd_ready);
        end
    endtask

    task automatic test_carry();
        logic [7:0] d; logic z, c, to; int lat;
        run_cmd(3'b100, 8'hFF, 8'h05, 1'b0, 0, d, z, c, lat, to);
        checks++;
        if (to || d !== 8'h04 || c !== 1'b1 || z !== 1'b0) begin
            errors++;
            $display("FAIL arith_carry: got %h c=%b z=%b, need 04 1 0", d, c, z);
        end
        run_cmd(3'b000, 8'hFF, 8'h05, 1'b0, 0, d, z, c, lat, to);
        ref_acc = 8'h05;
        checks++;
        if (to || d !== 8'h05 || c !== 1'b0) begin
            errors++;
            $display("FAIL logic_carry: got %h c=%b, need 05 0", d, c);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d; logic z, c, to; int lat;
        @(negedge clk);
        cmd_op = 3'b001; cmd_a = 8'h0C; cmd_b = 8'h30; cmd_use_acc = 1'b0;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        checks++;
        if (alu_a !== 8'h0C || alu_b !== 8'h30 || alu_s !== 2'b01) begin
            errors++;
            $display("FAIL mid_issue: a=%h b=%h s=%b, need 0C 30 01", alu_a, alu_b, alu_s);
        end
        rst = 1'b1;
        #1;
        ref_acc = '0;
        checks++;
        if ({alu_a, alu_b, alu_s, alu_unit, res_data, res_zero, res_carry} !== 29'd0 ||
            res_valid !== 1'b0 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: a=%h b=%h d=%h v=%b r=%b, need all 0", alu_a, alu_b, res_data, res_valid, cmd_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_release: ready=%b valid=%b, need 1 0", cmd_ready, res_valid);
        end
        run_cmd(3'b001, 8'hEE, 8'h11, 1'b1, 0, d, z, c, lat, to);
        ref_acc = 8'h11;
        checks++;
        if (to || d !== 8'h11) begin
            errors++;
            $display("FAIL mid_acc_cleared: got %h, need 11", d);
        end
    endtask

    task automatic test_random();
        logic [7:0] d, a, b, ea; logic z, c, to, ua; logic [2:0] op;
        logic [8:0] r; int lat, hold;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a = 8'($urandom); b = 8'($urandom);
            if ($urandom_range(0, 5) == 0) b = a;
            ua = 1'($urandom_range(0, 1));
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            run_cmd(op, a, b, ua, hold, d, z, c, lat, to);
            ea = ua ? ref_acc : a;
            r = env_alu(op, ea, b);
            ref_acc = r[7:0];
            checks++;
            if (to || lat != 2 || d !== r[7:0] || z !== (r[7:0] == 8'h00) ||
                c !== (op[2] & r[8])) begin
                errors++;
                $display("FAIL rand%0d: op=%b got %h z=%b c=%b lat=%0d, need %h z=%b c=%b lat=2",
                         i, op, d, z, c, lat, r[7:0], r[7:0] == 8'h00, op[2] & r[8]);
            end
`ifdef ALU_CMD_PARITY_EN
            checks++;
            if (res_parity !== ^r[7:0]) begin
                errors++;
                $display("FAIL rand_parity%0d: got %b, need %b", i, res_parity, ^r[7:0]);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_and();
        test_xor_not();
        test_accumulate();
        test_backpressure();
        test_carry();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
